// File: rtl/enlynx_pkg.sv
// Shared types and helpers for the enlynx counter bank: counting mode,
// per-channel configuration record and its reset-time default.
package enlynx_pkg;

    // Field widths of the configuration record; sized to cover any legal
    // bank instance (up to 256 event sources, counters up to 64 bits).
    localparam int CFG_SEL_W    = 8;
    localparam int CFG_THRESH_W = 64;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    typedef struct packed {
        logic [CFG_SEL_W-1:0]    sel;
        cnt_mode_e               mode;
        logic [CFG_THRESH_W-1:0] thresh;
    } chan_cfg_t;

    // Channel ch watches source (ch mod nEvents), wraps, and has no threshold.
    function automatic chan_cfg_t defaultCfg(input int ch, input int nEvents);
        chan_cfg_t cfg;
        cfg.sel    = CFG_SEL_W'(ch % nEvents);
        cfg.mode   = CNT_WRAP;
        cfg.thresh = '0;
        return cfg;
    endfunction

endpackage

// File: rtl/enlynx_counter_bank_channel.sv
// One performance counter: wrap/saturate arithmetic, threshold detection and
// the sticky overflow / threshold flags. The pre-clear next values are exported
// so the bank can snapshot the counter including the current cycle's events.
module enlynx_channel
    import enlynx_pkg::*;
#(
    parameter int INC_WIDTH     = 2,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INC_WIDTH-1:0]     i_inc,
    input  logic                     i_enable,
    input  logic                     i_sat,
    input  logic [CFG_THRESH_W-1:0]  i_thresh,
    input  logic                     i_clear,
    input  logic                     i_eop,
    output logic [COUNTER_WIDTH-1:0] o_cnt,
    output logic [COUNTER_WIDTH-1:0] o_nextCnt,
    output logic                     o_ovf,
    output logic                     o_nextOvf,
    output logic                     o_irq
);

    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic                     r_ovf;
    logic                     r_irq;

    logic [COUNTER_WIDTH:0]   w_sum;
    logic                     w_carry;
    logic [COUNTER_WIDTH-1:0] w_next;
    logic [CFG_THRESH_W-1:0]  w_cntExt;
    logic [CFG_THRESH_W-1:0]  w_nextExt;
    logic                     w_below;
    logic                     w_reached;
    logic                     w_cross;
    logic                     w_irqSet;
    logic                     w_nextOvf;
    logic                     w_nextIrq;

    // Next counter value: one extra bit catches the carry out of the add.
    always_comb begin
        w_sum   = {1'b0, r_cnt} + {{(COUNTER_WIDTH + 1 - INC_WIDTH){1'b0}}, i_inc};
        w_carry = i_enable & w_sum[COUNTER_WIDTH];
        if (!i_enable) begin
            w_next = r_cnt;
        end else if (w_carry && i_sat) begin
            w_next = '1;
        end else begin
            w_next = w_sum[COUNTER_WIDTH-1:0];
        end
    end

    // A wrap carry sweeps past the top, so any threshold above the old value
    // or at/below the new one has been crossed; otherwise it must lie between.
    always_comb begin
        w_cntExt  = CFG_THRESH_W'(r_cnt);
        w_nextExt = CFG_THRESH_W'(w_next);
        w_below   = (w_cntExt < i_thresh);
        w_reached = (w_nextExt >= i_thresh);
        if (w_carry && !i_sat) begin
            w_cross = w_below || w_reached;
        end else begin
            w_cross = w_below && w_reached;
        end
        w_irqSet  = (i_thresh != '0) && w_cross;
        w_nextOvf = r_ovf | w_carry;
        w_nextIrq = r_irq | w_irqSet;
    end

    // Counter and sticky flags; clear and end-of-period both zero them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_irq <= 1'b0;
        end else if (i_clear || i_eop) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_cnt <= w_next;
            r_ovf <= w_nextOvf;
            r_irq <= w_nextIrq;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_nextCnt = w_next;
    assign o_ovf     = r_ovf;
    assign o_nextOvf = w_nextOvf;
    assign o_irq     = r_irq;

endmodule

// File: rtl/enlynx_counter_bank.sv
// Bank of performance counters with runtime event selection, per-channel
// wrap/saturate mode and threshold interrupts, plus an end-of-period snapshot
// buffer handed to the readout layer over a valid/ready handshake.
module enlynx_counter_bank
    import enlynx_pkg::*;
#(
    parameter int N_EVENTS      = 8,
    parameter int N_CHANNELS    = 4,
    parameter int INC_WIDTH     = 2,
    parameter int COUNTER_WIDTH = 32,
    localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int SEL_W = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_EVENTS*INC_WIDTH-1:0]       events_i,
    input  logic [N_CHANNELS-1:0]               enable_i,
    input  logic                                cfg_we_i,
    input  logic [CH_W-1:0]                     cfg_ch_i,
    input  logic [SEL_W-1:0]                    cfg_sel_i,
    input  logic                                cfg_sat_i,
    input  logic [COUNTER_WIDTH-1:0]            cfg_thresh_i,
    input  logic                                clear_i,
    input  logic                                eop_i,
    output logic [N_CHANNELS*COUNTER_WIDTH-1:0] counters_o,
    output logic [N_CHANNELS-1:0]               overflow_o,
    output logic [N_CHANNELS-1:0]               thresh_irq_o,
    output logic [N_CHANNELS*COUNTER_WIDTH-1:0] snap_data_o,
    output logic [N_CHANNELS-1:0]               snap_ovf_o,
    output logic                                snap_valid_o,
    input  logic                                snap_ready_i,
    output logic                                snap_drop_o
);

    chan_cfg_t r_cfg [N_CHANNELS];

    logic [N_CHANNELS*COUNTER_WIDTH-1:0] r_snapData;
    logic [N_CHANNELS-1:0]               r_snapOvf;
    logic                                r_snapValid;
    logic                                r_snapDrop;

    chan_cfg_t                           w_cfgWrite;
    logic                                w_cfgChOk;
    logic [INC_WIDTH-1:0]                w_inc [N_CHANNELS];
    logic [COUNTER_WIDTH-1:0]            w_cnt [N_CHANNELS];
    logic [COUNTER_WIDTH-1:0]            w_nextCnt [N_CHANNELS];
    logic [N_CHANNELS*COUNTER_WIDTH-1:0] w_nextCntFlat;
    logic [N_CHANNELS-1:0]               w_ovf;
    logic [N_CHANNELS-1:0]               w_nextOvf;
    logic [N_CHANNELS-1:0]               w_irq;

    // Assemble the configuration record presented on the write port.
    always_comb begin
        w_cfgWrite.sel    = CFG_SEL_W'(cfg_sel_i);
        w_cfgWrite.mode   = cfg_sat_i ? CNT_SAT : CNT_WRAP;
        w_cfgWrite.thresh = CFG_THRESH_W'(cfg_thresh_i);
        w_cfgChOk         = (int'(cfg_ch_i) < N_CHANNELS);
    end

    // Configuration file; a write lands after the edge, so the write cycle
    // itself still counts with the previous settings.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                r_cfg[c] <= defaultCfg(c, N_EVENTS);
            end
        end else if (cfg_we_i && w_cfgChOk) begin
            r_cfg[cfg_ch_i] <= w_cfgWrite;
        end
    end

    // Per-channel event mux; a selector beyond the last source yields zero.
    always_comb begin
        for (int c = 0; c < N_CHANNELS; c++) begin
            w_inc[c] = '0;
            for (int k = 0; k < N_EVENTS; k++) begin
                if (r_cfg[c].sel == CFG_SEL_W'(k)) begin
                    w_inc[c] = events_i[k*INC_WIDTH +: INC_WIDTH];
                end
            end
        end
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan
        enlynx_channel #(
            .INC_WIDTH     (INC_WIDTH),
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_inc     (w_inc[c]),
            .i_enable  (enable_i[c]),
            .i_sat     (r_cfg[c].mode == CNT_SAT),
            .i_thresh  (r_cfg[c].thresh),
            .i_clear   (clear_i),
            .i_eop     (eop_i),
            .o_cnt     (w_cnt[c]),
            .o_nextCnt (w_nextCnt[c]),
            .o_ovf     (w_ovf[c]),
            .o_nextOvf (w_nextOvf[c]),
            .o_irq     (w_irq[c])
        );

        assign counters_o[c*COUNTER_WIDTH +: COUNTER_WIDTH]    = w_cnt[c];
        assign w_nextCntFlat[c*COUNTER_WIDTH +: COUNTER_WIDTH] = w_nextCnt[c];
    end

    // Snapshot buffer: end-of-period loads it (overwriting and flagging a drop
    // if the consumer has not taken the previous one); an accept empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snapData  <= '0;
            r_snapOvf   <= '0;
            r_snapValid <= 1'b0;
            r_snapDrop  <= 1'b0;
        end else begin
            r_snapDrop <= 1'b0;
            if (eop_i) begin
                r_snapData  <= w_nextCntFlat;
                r_snapOvf   <= w_nextOvf;
                r_snapValid <= 1'b1;
                r_snapDrop  <= r_snapValid && !snap_ready_i;
            end else if (r_snapValid && snap_ready_i) begin
                r_snapValid <= 1'b0;
            end
        end
    end

    assign overflow_o   = w_ovf;
    assign thresh_irq_o = w_irq;
    assign snap_data_o  = r_snapData;
    assign snap_ovf_o   = r_snapOvf;
    assign snap_valid_o = r_snapValid;
    assign snap_drop_o  = r_snapDrop;

endmodule
